counter: RTL and testbench
==========================

COUNTER -- requirements
Module: counter

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset; there SHALL be no other clock or reset.
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 en  input  1  counter enable from the register block; 0 = hold all state.
REQ-005 count_reset  input  1  one-cycle clear pulse from the register block.
REQ-006 upnotdown  input  1  1 = count up, 0 = count down.
REQ-007 prescale  input  8  counter advances once per (prescale+1) enabled clocks.
REQ-008 period  input  16  terminal value; count range is 0..period inclusive.
REQ-009 counter_val  output  16  current count, registered; fed back to the register block for readback.
REQ-010 wrap  output  1  registered one-cycle pulse, asserted in the cycle after counter_val wraps.

Function
REQ-011 Prescaler: 8-bit psc_cnt; when en=1, tick=1 iff psc_cnt >= prescale, then psc_cnt<=0, else psc_cnt<=psc_cnt+1.
REQ-012 Prescale change mid-run takes effect on the next compare; a new prescale <= psc_cnt SHALL tick on the next enabled clock.
REQ-013 On tick in up mode: counter_val >= period -> counter_val<=0 and wrap<=1; else counter_val<=counter_val+1.
REQ-014 On tick in down mode: counter_val==0 -> counter_val<=period and wrap<=1; counter_val>period -> counter_val<=period, wrap<=0; else counter_val<=counter_val-1.
REQ-015 period=0: counter_val stays 0 and wrap pulses on every tick, in either direction.
REQ-016 Direction change SHALL continue from the current counter_val with no skip or extra wrap.
REQ-017 Period reduced below counter_val: up mode wraps to 0 on the next tick; down mode loads the new period on the next tick without a wrap pulse.
REQ-018 en=0: counter_val and psc_cnt hold; wrap=0.
REQ-019 count_reset=1: next cycle counter_val=0, psc_cnt=0, wrap=0, regardless of en; count_reset has priority over tick.
REQ-020 wrap SHALL be 0 in every cycle not described in REQ-013/014/015.
REQ-021 Arithmetic SHALL be 16-bit unsigned; no value outside 0..max(period, previous counter_val) SHALL ever appear on counter_val.
REQ-022 Latency: first tick occurs (prescale+1) clocks after en rises from a cleared prescaler.

Reset
REQ-023 rst=1 at a rising edge SHALL set counter_val=0, psc_cnt=0, wrap=0; rst has priority over count_reset and en.
REQ-024 Reset mid-count SHALL discard the partial prescale interval; counting resumes from 0 under REQ-022 after rst falls.

Structure
REQ-025 The shared PWM package SHALL hold CNT_W=16 and PSC_W=8, which the register block also uses.
REQ-026 The prescaler (REQ-011/012, clear by rst or count_reset) SHALL be a sub-module named prescaler, outputting tick.
REQ-027 All outputs SHALL be registered; no combinational path from any input to counter_val or wrap.

Verification
REQ-028 Reset: rst=1 for 2 clocks with en=1, period=5 -> counter_val=0, wrap=0 throughout.
REQ-029 Up, prescale=0, period=3, en=1 -> counter_val 0,1,2,3,0,1...; wrap high exactly one cycle after each 3->0.
REQ-030 Down, prescale=2, period=4 from 0 -> counter_val 4 after 3 clocks with wrap pulse, then 3,2,1,0 each held 3 clocks.
REQ-031 Up at counter_val=10, period changed to 5 -> next tick counter_val=0, wrap=1; en=0 for 5 clocks -> value and wrap frozen.
REQ-032 count_reset pulse with en=1 at counter_val=7, same cycle as a tick -> counter_val=0 next cycle, no wrap.
REQ-033 period=0, prescale=1 -> counter_val constant 0, wrap pulses every 2nd clock.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared PWM definitions: datapath widths used by the counter and the register block.
package pwm_pkg;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned PSC_W = 8;

endpackage

// File: rtl/prescaler.sv
// Prescaler: pulses tick once every (prescale+1) enabled clocks.
module prescaler
    import pwm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [PSC_W-1:0] prescale,
    output logic             tick
);

    logic [PSC_W-1:0] psc_cnt_q;
    logic [PSC_W-1:0] psc_cnt_d;

    // >= rather than == so a prescale lowered below psc_cnt ticks at once.
    assign tick = en && (psc_cnt_q >= prescale);

    always_comb begin
        psc_cnt_d = psc_cnt_q;
        if (clr) begin
            psc_cnt_d = '0;
        end else if (en) begin
            psc_cnt_d = tick ? '0 : psc_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            psc_cnt_q <= '0;
        end else begin
            psc_cnt_q <= psc_cnt_d;
        end
    end

endmodule

// File: rtl/counter.sv
// PWM base counter: up/down count over 0..period with a registered wrap pulse.
module counter
    import pwm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             count_reset,
    input  logic             upnotdown,
    input  logic [PSC_W-1:0] prescale,
    input  logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] counter_val,
    output logic             wrap
);

    logic             tick;
    logic [CNT_W-1:0] counter_val_q;
    logic [CNT_W-1:0] counter_val_d;
    logic             wrap_q;
    logic             wrap_d;

    prescaler u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .clr      (count_reset),
        .en       (en),
        .prescale (prescale),
        .tick     (tick)
    );

    always_comb begin
        counter_val_d = counter_val_q;
        wrap_d        = 1'b0;
        if (count_reset) begin
            counter_val_d = '0;
        end else if (tick) begin
            if (upnotdown) begin
                if (counter_val_q >= period) begin
                    counter_val_d = '0;
                    wrap_d        = 1'b1;
                end else begin
                    counter_val_d = counter_val_q + 1'b1;
                end
            end else begin
                if (counter_val_q == '0) begin
                    counter_val_d = period;
                    wrap_d        = 1'b1;
                end else if (counter_val_q > period) begin
                    // Period shrank under us: reload silently.
                    counter_val_d = period;
                end else begin
                    counter_val_d = counter_val_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter_val_q <= '0;
            wrap_q        <= 1'b0;
        end else begin
            counter_val_q <= counter_val_d;
            wrap_q        <= wrap_d;
        end
    end

    assign counter_val = counter_val_q;
    assign wrap        = wrap_q;

endmodule

// File: tb/tb_counter.sv
// Scoreboard bench for counter: driver queues hand-computed per-cycle expectations.
module tb_counter;
    import pwm_pkg::*;

    logic             clk;
    logic             rst;
    logic             en;
    logic             count_reset;
    logic             upnotdown;
    logic [PSC_W-1:0] prescale;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] counter_val;
    logic             wrap;

    typedef struct {
        logic [CNT_W-1:0] cnt;
        logic             wrap;
        int               id;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_id  = 0;
    bit   done     = 0;

    counter dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .count_reset (count_reset),
        .upnotdown   (upnotdown),
        .prescale    (prescale),
        .period      (period),
        .counter_val (counter_val),
        .wrap        (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every output cycle with a pending expectation is compared.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (counter_val !== e.cnt || wrap !== e.wrap) begin
                failures++;
                $display("FAIL step%0d: counter_val=%0d wrap=%b, required counter_val=%0d wrap=%b",
                         e.id, counter_val, wrap, e.cnt, e.wrap);
            end
        end
    end

    // Inputs are already set by the caller; one clock edge, expected outputs after it.
    task automatic step(input logic [CNT_W-1:0] ec, input logic ew);
        exp_t e;
        @(negedge clk);
        step_id++;
        e.cnt  = ec;
        e.wrap = ew;
        e.id   = step_id;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n, input logic [CNT_W-1:0] ec, input logic ew);
        for (int i = 0; i < n; i++) step(ec, ew);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; count_reset = 1'b0; upnotdown = 1'b1;
        prescale = 8'd0; period = 16'd5;

        // Reset held two clocks with en=1
        run(2, 16'd0, 1'b0);
        rst = 1'b0;

        // Up, prescale 0, period 3
        period = 16'd3;
        step(1, 0); step(2, 0); step(3, 0); step(0, 1);
        step(1, 0); step(2, 0); step(3, 0); step(0, 1); step(1, 0);
        count_reset = 1'b1; step(0, 0); count_reset = 1'b0;

        // Down, prescale 2, period 4 from 0
        upnotdown = 1'b0; prescale = 8'd2; period = 16'd4;
        run(2, 0, 0); step(4, 1); run(2, 4, 0);
        run(3, 3, 0); run(3, 2, 0); run(3, 1, 0); run(3, 0, 0); step(4, 1);

        // Up to 10, then period cut to 5, then en=0 freeze
        count_reset = 1'b1; step(0, 0); count_reset = 1'b0;
        upnotdown = 1'b1; prescale = 8'd0; period = 16'd20;
        for (int i = 1; i <= 10; i++) step(i[CNT_W-1:0], 0);
        period = 16'd5; step(0, 1); step(1, 0);
        en = 1'b0; run(5, 1, 0);
        en = 1'b1; period = 16'd20;
        for (int i = 2; i <= 7; i++) step(i[CNT_W-1:0], 0);

        // count_reset on a would-be wrap tick at 7
        period = 16'd7; count_reset = 1'b1; step(0, 0); count_reset = 1'b0;

        // period 0, prescale 1: wrap every second clock, both directions
        period = 16'd0; prescale = 8'd1;
        step(0, 0); step(0, 1); step(0, 0); step(0, 1);
        upnotdown = 1'b0; step(0, 0); step(0, 1);

        // Direction changes mid-run
        count_reset = 1'b1; step(0, 0); count_reset = 1'b0;
        prescale = 8'd0; period = 16'd5; upnotdown = 1'b1;
        step(1, 0); step(2, 0); step(3, 0);
        upnotdown = 1'b0; step(2, 0); step(1, 0); step(0, 0); step(5, 1); step(4, 0);
        upnotdown = 1'b1; step(5, 0); step(0, 1);

        // Down mode with period reduced below counter_val
        period = 16'd9; step(1, 0); step(2, 0); step(3, 0); step(4, 0);
        upnotdown = 1'b0; period = 16'd2; step(2, 0); step(1, 0); step(0, 0); step(2, 1);

        // Reset mid prescale interval, then prescale lowered below psc_cnt
        count_reset = 1'b1; step(0, 0); count_reset = 1'b0;
        upnotdown = 1'b1; prescale = 8'd3; period = 16'd9;
        run(3, 0, 0); step(1, 0); step(1, 0);
        rst = 1'b1; count_reset = 1'b1; step(0, 0); rst = 1'b0; count_reset = 1'b0;
        run(3, 0, 0); step(1, 0);
        step(1, 0); step(1, 0);
        prescale = 8'd1; step(2, 0);

        @(negedge clk); @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL timeout: bench did not complete, required completion");
            $fatal(1, "timeout");
        end
    end

endmodule
